// File: rtl/clkgen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clkgen_pkg
//  Description : Shared types for the clock/reset sequencer: FSM state
//                encoding, 16-bit cycle-counter type, retry-counter width
//                and a saturating increment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package clkgen_pkg;

   localparam int RETRY_W = 4;

   typedef logic [RETRY_W-1:0] retry_t;
   typedef logic [15:0]        cnt_t;

   typedef enum logic [2:0] {
      ST_DCM_RST  = 3'd0,
      ST_DCM_WAIT = 3'd1,
      ST_PLL_RST  = 3'd2,
      ST_PLL_WAIT = 3'd3,
      ST_REL_DDR  = 3'd4,
      ST_REL_WB   = 3'd5,
      ST_RUN      = 3'd6,
      ST_FAULT    = 3'd7
   } state_t;

   // Retry counter stops at all-ones instead of wrapping back to zero
   function automatic retry_t sat_inc(input retry_t v);
      return (v == '1) ? v : v + retry_t'(1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/clk_rst_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : clk_rst_sequencer_if
//  Description : Board-side signal bundle of the clock/reset sequencer:
//                lock inputs, soft-reset request, reset outputs and status.
//                master = sequencer side, slave = board/clock-generator side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface clk_rst_sequencer_if;
   import clkgen_pkg::*;

   logic   dcm_locked_i;
   logic   pll_locked_i;
   logic   soft_rst_i;
   logic   dcm_rst_o;
   logic   pll_rst_o;
   logic   ddr2_rst_o;
   logic   wb_rst_o;
   logic   seq_done_o;
   logic   fault_o;
   retry_t retry_cnt_o;

   modport master (
      input  dcm_locked_i, pll_locked_i, soft_rst_i,
      output dcm_rst_o, pll_rst_o, ddr2_rst_o, wb_rst_o,
             seq_done_o, fault_o, retry_cnt_o
   );

   modport slave (
      output dcm_locked_i, pll_locked_i, soft_rst_i,
      input  dcm_rst_o, pll_rst_o, ddr2_rst_o, wb_rst_o,
             seq_done_o, fault_o, retry_cnt_o
   );

endinterface
`default_nettype wire

// File: rtl/lock_sync.sv
`default_nettype none
// ============================================================================
//  Module      : lock_sync
//  Description : Two-flop synchronizer for an asynchronous lock level.
//                Clears to 0 so a fresh sequence never sees a stale lock.
//  Revision    : 1.0 - initial release
// ============================================================================
module lock_sync (
   input  wire  clk,
   input  wire  rst,
   input  wire  din,
   output logic dout
);

   logic meta;

   // Two-stage capture of the asynchronous lock into the clk domain
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         dout <= 1'b0;
      end else begin
         meta <= din;
         dout <= meta;
      end
   end

endmodule
`default_nettype wire

// File: rtl/clk_rst_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : clk_rst_sequencer
//  Description : Brings up DCM then PLL, waits for each lock with a timeout
//                and retry budget, then releases the DDR2 domain reset ahead
//                of the bus domain reset. Supports soft domain re-reset and
//                lock-loss handling while running.
//                Optional macro CLKSEQ_LOSS_RECOVERY_EN: lock loss in RUN
//                re-locks the affected clock instead of entering FAULT.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_rst_sequencer
   import clkgen_pkg::*;
#(
   parameter int RST_HOLD     = 16,
   parameter int LOCK_TIMEOUT = 50000,
   parameter int STAGE_DELAY  = 8,
   parameter int MAX_RETRY    = 3
) (
   input  wire                  sys_clk_i,
   input  wire                  sys_rst_i,
   clk_rst_sequencer_if.master  bus
);

   localparam cnt_t   HOLD_LAST    = cnt_t'(RST_HOLD - 1);
   localparam cnt_t   TIMEOUT_LAST = cnt_t'(LOCK_TIMEOUT - 1);
   localparam cnt_t   STAGE_LAST   = cnt_t'(STAGE_DELAY - 1);
   localparam retry_t RETRY_LIMIT  = retry_t'(MAX_RETRY);

   state_t state, state_nxt;
   cnt_t   cnt;
   retry_t retry, retry_nxt;
   logic   timeout;

   logic   dcm_lock_s, pll_lock_s;

   logic   dcm_rst, pll_rst, ddr2_rst, wb_rst, seq_done, fault;
   logic   dcm_rst_nxt, pll_rst_nxt, ddr2_rst_nxt, wb_rst_nxt;
   logic   seq_done_nxt, fault_nxt;

   lock_sync u_dcm_sync (
      .clk  (sys_clk_i),
      .rst  (sys_rst_i),
      .din  (bus.dcm_locked_i),
      .dout (dcm_lock_s)
   );

   lock_sync u_pll_sync (
      .clk  (sys_clk_i),
      .rst  (sys_rst_i),
      .din  (bus.pll_locked_i),
      .dout (pll_lock_s)
   );

   // State, cycle counter, retry count and registered outputs
   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
         state    <= ST_DCM_RST;
         cnt      <= '0;
         retry    <= '0;
         dcm_rst  <= 1'b1;
         pll_rst  <= 1'b1;
         ddr2_rst <= 1'b1;
         wb_rst   <= 1'b1;
         seq_done <= 1'b0;
         fault    <= 1'b0;
      end else begin
         state    <= state_nxt;
         // Counter restarts on every state entry; parks at max in RUN/FAULT
         if (state_nxt != state)
            cnt <= '0;
         else if (cnt != '1)
            cnt <= cnt + cnt_t'(1);
         retry    <= retry_nxt;
         dcm_rst  <= dcm_rst_nxt;
         pll_rst  <= pll_rst_nxt;
         ddr2_rst <= ddr2_rst_nxt;
         wb_rst   <= wb_rst_nxt;
         seq_done <= seq_done_nxt;
         fault    <= fault_nxt;
      end
   end

   // Next-state, retry accounting and output decode of the next state
   always_comb begin
      state_nxt = state;
      retry_nxt = retry;
      timeout   = 1'b0;

      case (state)
         ST_DCM_RST: begin
            if (cnt == HOLD_LAST)
               state_nxt = ST_DCM_WAIT;
         end
         ST_DCM_WAIT: begin
            if (dcm_lock_s)
               state_nxt = ST_PLL_RST;
            else if (cnt == TIMEOUT_LAST)
               timeout = 1'b1;
         end
         ST_PLL_RST: begin
            // PLL needs a stable reference; a lost DCM restarts from scratch
            if (!dcm_lock_s)
               state_nxt = ST_DCM_RST;
            else if (cnt == HOLD_LAST)
               state_nxt = ST_PLL_WAIT;
         end
         ST_PLL_WAIT: begin
            if (!dcm_lock_s)
               state_nxt = ST_DCM_RST;
            else if (pll_lock_s)
               state_nxt = ST_REL_DDR;
            else if (cnt == TIMEOUT_LAST)
               timeout = 1'b1;
         end
         ST_REL_DDR: begin
            if (cnt == STAGE_LAST)
               state_nxt = ST_REL_WB;
         end
         ST_REL_WB: begin
            if (cnt == STAGE_LAST)
               state_nxt = ST_RUN;
         end
         ST_RUN: begin
            // Lock loss outranks a soft reset request
            if (!dcm_lock_s || !pll_lock_s) begin
`ifdef CLKSEQ_LOSS_RECOVERY_EN
               state_nxt = !dcm_lock_s ? ST_DCM_RST : ST_PLL_RST;
`else
               state_nxt = ST_FAULT;
`endif
            end else if (bus.soft_rst_i) begin
               state_nxt = ST_REL_DDR;
            end
         end
         ST_FAULT: begin
            state_nxt = ST_FAULT;
         end
         default: begin
            state_nxt = ST_DCM_RST;
         end
      endcase

      if (timeout) begin
         retry_nxt = sat_inc(retry);
         state_nxt = (retry_nxt == RETRY_LIMIT) ? ST_FAULT : ST_DCM_RST;
      end

      dcm_rst_nxt  = (state_nxt == ST_DCM_RST) || (state_nxt == ST_FAULT);
      pll_rst_nxt  = (state_nxt == ST_DCM_RST)  || (state_nxt == ST_DCM_WAIT) ||
                     (state_nxt == ST_PLL_RST)  || (state_nxt == ST_FAULT);
      ddr2_rst_nxt = !((state_nxt == ST_REL_WB) || (state_nxt == ST_RUN));
      wb_rst_nxt   = (state_nxt != ST_RUN);
      seq_done_nxt = (state_nxt == ST_RUN);
      fault_nxt    = (state_nxt == ST_FAULT);
   end

   assign bus.dcm_rst_o   = dcm_rst;
   assign bus.pll_rst_o   = pll_rst;
   assign bus.ddr2_rst_o  = ddr2_rst;
   assign bus.wb_rst_o    = wb_rst;
   assign bus.seq_done_o  = seq_done;
   assign bus.fault_o     = fault;
   assign bus.retry_cnt_o = retry;

endmodule
`default_nettype wire

// File: tb/tb_clk_rst_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_rst_sequencer
//  Description : Directed self-checking bench for clk_rst_sequencer with
//                RST_HOLD=4, STAGE_DELAY=2, LOCK_TIMEOUT=100, MAX_RETRY=2.
//                Expectations follow CLKSEQ_LOSS_RECOVERY_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_rst_sequencer;

   logic clk = 1'b0;
   logic rst;
   int   n_pass  = 0;
   int   n_fail  = 0;
   int   n_total = 0;

   clk_rst_sequencer_if bus ();

   clk_rst_sequencer #(
      .RST_HOLD     (4),
      .LOCK_TIMEOUT (100),
      .STAGE_DELAY  (2),
      .MAX_RETRY    (2)
   ) dut (
      .sys_clk_i (clk),
      .sys_rst_i (rst),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic sig(input int idx);
      case (idx)
         0:       return bus.dcm_rst_o;
         1:       return bus.pll_rst_o;
         2:       return bus.ddr2_rst_o;
         3:       return bus.wb_rst_o;
         4:       return bus.seq_done_o;
         default: return bus.fault_o;
      endcase
   endfunction

   task automatic wait_sig(input string tag, input int idx, input logic val, input int limit);
      int n = 0;
      while (sig(idx) !== val && n < limit) begin
         @(negedge clk);
         n++;
      end
      check(tag, {31'd0, sig(idx)}, {31'd0, val});
   endtask

   task automatic check_reset_vals(input string pfx);
      check({pfx, "_dcm"},   {31'd0, bus.dcm_rst_o},  1);
      check({pfx, "_pll"},   {31'd0, bus.pll_rst_o},  1);
      check({pfx, "_ddr2"},  {31'd0, bus.ddr2_rst_o}, 1);
      check({pfx, "_wb"},    {31'd0, bus.wb_rst_o},   1);
      check({pfx, "_done"},  {31'd0, bus.seq_done_o}, 0);
      check({pfx, "_fault"}, {31'd0, bus.fault_o},    0);
      check({pfx, "_retry"}, {28'd0, bus.retry_cnt_o}, 0);
   endtask

   // Directed scenario sequence, sampling and driving on the falling edge
   initial begin
      int n, cd, cw, cp, bad, dseen;
      rst = 1'b1;
      bus.dcm_locked_i = 1'b0;
      bus.pll_locked_i = 1'b0;
      bus.soft_rst_i   = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_vals("por");

      // Normal bring-up: locks arrive 10 cycles after each reset release
      rst = 1'b0;
      n = 0;
      while (bus.dcm_rst_o && n < 50) begin n++; @(negedge clk); end
      check("dcm_hold", n, 4);
      repeat (10) @(negedge clk);
      bus.dcm_locked_i = 1'b1;
      wait_sig("pll_rel", 1, 1'b0, 100);
      repeat (10) @(negedge clk);
      bus.pll_locked_i = 1'b1;
      wait_sig("ddr_rel", 2, 1'b0, 100);
      check("ddr_before_wb", {31'd0, bus.wb_rst_o}, 1);
      n = 0;
      while (bus.wb_rst_o && n < 50) begin @(negedge clk); n++; end
      check("stage_gap", n, 2);
      check("run_done",  {31'd0, bus.seq_done_o}, 1);
      check("run_retry", {28'd0, bus.retry_cnt_o}, 0);
      check("run_dcm",   {31'd0, bus.dcm_rst_o}, 0);
      check("run_pll",   {31'd0, bus.pll_rst_o}, 0);

      // Soft reset from RUN: domain resets only
      @(negedge clk); bus.soft_rst_i = 1'b1;
      @(negedge clk); bus.soft_rst_i = 1'b0;
      cd = 0; cw = 0; bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.ddr2_rst_o) cd++;
         if (bus.wb_rst_o) cw++;
         if (bus.dcm_rst_o || bus.pll_rst_o) bad++;
         @(negedge clk);
      end
      check("soft_ddr2_cycles", cd, 2);
      check("soft_wb_cycles",   cw, 4);
      check("soft_clk_rst",     bad, 0);
      check("soft_done",        {31'd0, bus.seq_done_o}, 1);

      // One-cycle PLL lock glitch in RUN
      bus.pll_locked_i = 1'b0;
      @(negedge clk); bus.pll_locked_i = 1'b1;
      cp = 0; bad = 0; dseen = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.pll_rst_o) cp++;
         if (bus.dcm_rst_o) bad++;
         if (bus.ddr2_rst_o && bus.wb_rst_o) dseen = 1;
         @(negedge clk);
      end
      check("glitch_domain_rst", dseen, 1);
`ifdef CLKSEQ_LOSS_RECOVERY_EN
      check("glitch_pll_cycles", cp, 4);
      check("glitch_dcm_rst",    bad, 0);
      check("glitch_done",       {31'd0, bus.seq_done_o}, 1);
      check("glitch_retry",      {28'd0, bus.retry_cnt_o}, 0);
`else
      check("glitch_fault",   {31'd0, bus.fault_o},    1);
      check("glitch_dcm_rst", {31'd0, bus.dcm_rst_o},  1);
      check("glitch_pll_rst", {31'd0, bus.pll_rst_o},  1);
      check("glitch_done",    {31'd0, bus.seq_done_o}, 0);
`endif

      // First attempt times out, second attempt reaches PLL_WAIT, then reset
      rst = 1'b1;
      bus.dcm_locked_i = 1'b0;
      bus.pll_locked_i = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      n = 0;
      while (bus.retry_cnt_o != 4'd1 && n < 300) begin @(negedge clk); n++; end
      check("first_timeout_at", n, 104);
      wait_sig("dcm_rel2", 0, 1'b0, 50);
      repeat (10) @(negedge clk);
      bus.dcm_locked_i = 1'b1;
      wait_sig("pll_rel2", 1, 1'b0, 100);
      check("pllwait_retry", {28'd0, bus.retry_cnt_o}, 1);
      rst = 1'b1;
      @(negedge clk);
      check_reset_vals("midrst");

      // Restart with full hold, DCM lock never arrives: two timeouts -> FAULT
      bus.dcm_locked_i = 1'b0;
      rst = 1'b0;
      n = 0;
      while (bus.dcm_rst_o && n < 50) begin n++; @(negedge clk); end
      check("restart_hold", n, 4);
      while (!bus.fault_o && n < 400) begin @(negedge clk); n++; end
      check("fault_at",       n, 208);
      check("fault_retry",    {28'd0, bus.retry_cnt_o}, 2);
      check("fault_all_rst",  {28'd0, bus.dcm_rst_o, bus.pll_rst_o, bus.ddr2_rst_o, bus.wb_rst_o}, 4'hF);
      check("fault_done",     {31'd0, bus.seq_done_o}, 0);
      bus.soft_rst_i = 1'b1;
      @(negedge clk); bus.soft_rst_i = 1'b0;
      repeat (20) @(negedge clk);
      check("fault_sticky",   {31'd0, bus.fault_o}, 1);
      rst = 1'b1;
      @(negedge clk);
      check("fault_clr",       {31'd0, bus.fault_o}, 0);
      check("fault_clr_retry", {28'd0, bus.retry_cnt_o}, 0);
      rst = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/clk_rst_sequencer.md
CLK_RST_SEQUENCER -- requirements
Module: clk_rst_sequencer

Interface
REQ-001 Parameter RST_HOLD, default 16, cycles dcm_rst_o/pll_rst_o are held asserted per attempt (1..65535).
REQ-002 Parameter LOCK_TIMEOUT, default 50000, cycles to wait for a lock before the attempt fails (1..65535).
REQ-003 Parameter STAGE_DELAY, default 8, cycles between consecutive domain-reset releases (1..65535).
REQ-004 Parameter MAX_RETRY, default 3, failed attempts tolerated before FAULT (1..15).
REQ-005 sys_clk_i  in  1  free-running buffered board clock; the only clock.
REQ-006 sys_rst_i  in  1  reset, synchronous to sys_clk_i, active-high.
REQ-007 dcm_locked_i  in  1  DCM lock, asynchronous.
REQ-008 pll_locked_i  in  1  PLL lock, asynchronous.
REQ-009 soft_rst_i  in  1  single-cycle request to re-reset the domains without re-locking the clocks.
REQ-010 dcm_rst_o  out  1  DCM reset, active-high.
REQ-011 pll_rst_o  out  1  PLL reset, active-high.
REQ-012 ddr2_rst_o  out  1  memory-interface reset, active-high.
REQ-013 wb_rst_o  out  1  bus/peripheral reset, active-high.
REQ-014 seq_done_o  out  1  high only in RUN.
REQ-015 fault_o  out  1  high only in FAULT.
REQ-016 retry_cnt_o  out  4  failed attempts since sys_rst_i.

Function
REQ-017 All outputs SHALL be registered; lock inputs SHALL pass a 2-flop synchronizer (2-cycle latency) before use.
REQ-018 States: DCM_RST, DCM_WAIT, PLL_RST, PLL_WAIT, REL_DDR, REL_WB, RUN, FAULT; one 16-bit cycle counter, cleared on every state entry.
REQ-019 DCM_RST: dcm_rst_o=1, pll_rst_o=1; after RST_HOLD cycles -> DCM_WAIT.
REQ-020 DCM_WAIT: dcm_rst_o=0; synced DCM lock -> PLL_RST; counter reaching LOCK_TIMEOUT -> timeout event.
REQ-021 PLL_RST: pll_rst_o=1 for RST_HOLD cycles -> PLL_WAIT; synced DCM lock loss in PLL_RST/PLL_WAIT -> DCM_RST without retry increment.
REQ-022 PLL_WAIT: pll_rst_o=0; synced PLL lock -> REL_DDR; LOCK_TIMEOUT -> timeout event.
REQ-023 Timeout event: retry_cnt_o increments (saturating at 15); if new value equals MAX_RETRY -> FAULT, else -> DCM_RST.
REQ-024 REL_DDR: after STAGE_DELAY cycles ddr2_rst_o falls on state exit -> REL_WB.
REQ-025 REL_WB: after STAGE_DELAY cycles wb_rst_o falls on state exit -> RUN; ddr2_rst_o SHALL always be released strictly before wb_rst_o.
REQ-026 ddr2_rst_o and wb_rst_o SHALL be 1 in every state except RUN and the released portion of REL_WB (ddr2_rst_o only).
REQ-027 RUN: soft_rst_i -> REL_DDR with ddr2_rst_o=wb_rst_o=1 on the next cycle, dcm/pll resets untouched; soft_rst_i ignored outside RUN.
REQ-028 Lock loss in RUN (either synced lock low) has priority over soft_rst_i; handling per REQ-032/033; both domain resets assert the next cycle.
REQ-029 FAULT: all four resets held 1; exited only by sys_rst_i.

Reset
REQ-030 sys_rst_i high SHALL, next edge and from any state: state DCM_RST, counter 0, retry_cnt_o 0, synchronizers 0, dcm_rst_o=pll_rst_o=ddr2_rst_o=wb_rst_o=1, seq_done_o=fault_o=0.
REQ-031 Reset asserted mid-sequence SHALL restart from DCM_RST with full RST_HOLD.

Configuration
REQ-032 With CLKSEQ_LOSS_RECOVERY_EN defined: DCM lock loss in RUN -> DCM_RST; PLL-only loss -> PLL_RST; retry_cnt_o unchanged.
REQ-033 Without CLKSEQ_LOSS_RECOVERY_EN: any lock loss in RUN -> FAULT.

Structure
REQ-034 Package clkgen_pkg SHALL hold the state enum, 16-bit counter type and retry width constant.
REQ-035 Sub-module lock_sync (2-flop synchronizer, reset to 0) SHALL be instantiated once per lock input.

Verification (RST_HOLD=4, STAGE_DELAY=2, LOCK_TIMEOUT=100, MAX_RETRY=2)
REQ-036 Locks rise 10 cycles after each respective reset release -> dcm_rst_o high exactly 4 cycles, ddr2_rst_o falls 2 cycles before wb_rst_o, seq_done_o=1, retry_cnt_o=0.
REQ-037 dcm_locked_i held 0 -> two 100-cycle timeouts, retry_cnt_o=2, fault_o=1, all resets 1 until sys_rst_i pulse.
REQ-038 In RUN, pll_locked_i drops 1 cycle (macro on) -> ddr2_rst_o/wb_rst_o rise, pll_rst_o high 4 cycles, dcm_rst_o stays 0, RUN regained; macro off -> fault_o=1.
REQ-039 In RUN, soft_rst_i pulse -> domain resets high 2 cycles (ddr2) / 4 cycles (wb), DCM/PLL resets stay 0.
REQ-040 sys_rst_i asserted in PLL_WAIT -> all outputs at reset values next cycle, sequence restarts, retry_cnt_o=0.
